// File: rtl/rv32i_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_encoder_loader
// Description : Packs decoded RV32I fields into machine words and streams them
//               sequentially into instruction memory over a write handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [ADDR_W-1:0]   r_word_count;
    logic [1:0]          r_err;
    logic                r_last_pending;

    logic                w_wr_done;
    logic                w_accept;
    logic                w_in_ready;
    logic                w_fmt_ok;
    logic                w_start_load;
    logic                w_to_done;
    logic [ADDR_W:0]     w_occupied;
    logic [ADDR_W:0]     w_count_inc;
    logic [31:0]         w_word;

    assign w_wr_done    = r_mem_we && mem_ready;
    assign w_fmt_ok     = (in_fmt <= 3'd5);
    assign w_occupied   = {1'b0, r_word_count} + {{ADDR_W{1'b0}}, r_mem_we};
    assign w_count_inc  = {1'b0, r_word_count} + {{ADDR_W{1'b0}}, 1'b1};
    // The output slot frees up in the same cycle it drains, allowing one word per cycle.
    assign w_in_ready   = (r_state == ST_LOAD) && !r_last_pending &&
                          (!r_mem_we || mem_ready) && (w_occupied < C_DEPTH);
    assign w_accept     = in_valid && w_in_ready;
    assign w_start_load = start && (r_state != ST_LOAD);
    assign w_to_done    = (w_wr_done && (r_last_pending || (w_count_inc == C_DEPTH))) ||
                          (w_accept && !w_fmt_ok && in_last);

    always_comb begin
        w_word = 32'd0;
        case (in_fmt)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            3'd4: w_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
            default: w_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (w_to_done) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) w_state_next = ST_LOAD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we       <= 1'b0;
            r_mem_addr     <= C_BASE;
            r_mem_wdata    <= 32'd0;
            r_word_count   <= '0;
            r_err          <= 2'b00;
            r_last_pending <= 1'b0;
        end else if (w_start_load) begin
            r_mem_we       <= 1'b0;
            r_mem_addr     <= C_BASE;
            r_word_count   <= '0;
            r_err          <= 2'b00;
            r_last_pending <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            if (w_wr_done) begin
                r_word_count <= r_word_count + ADDR_W'(1);
                r_mem_addr   <= r_mem_addr + ADDR_W'(4);
            end
            // Illegal formats are consumed without occupying the output slot.
            if (w_accept && w_fmt_ok) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_word;
                if (in_last) r_last_pending <= 1'b1;
            end else if (w_wr_done) begin
                r_mem_we <= 1'b0;
            end
            if (w_accept) begin
                if (!w_fmt_ok) r_err[0] <= 1'b1;
                if (((in_fmt == 3'd3) || (in_fmt == 3'd5)) && in_imm[0]) r_err[1] <= 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;
    assign err        = r_err;

endmodule
`default_nettype wire
